// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier, one partial product per clock.
// Optional two's-complement operands when MULT_SIGNED_EN is defined.
`timescale 1ns/1ps
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_add;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [CW-1:0]      cnt;
    logic               last;

    assign acc_add = mplier[0] ? acc + mcand : acc;
    assign last    = (cnt == CW'(WIDTH - 1));
    assign ready   = (state == IDLE);
    assign done    = (state == DONE);

`ifdef MULT_SIGNED_EN
    logic sign;

    // Magnitude of the most-negative value wraps to itself, read as unsigned.
    assign a_mag    = operand_a[WIDTH-1] ? -operand_a : operand_a;
    assign b_mag    = operand_b[WIDTH-1] ? -operand_b : operand_b;
    assign prod_fin = sign ? -acc_add : acc_add;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sign <= 1'b0;
        end else if (state == IDLE && start) begin
            sign <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
        end
    end
`else
    assign a_mag    = operand_a;
    assign b_mag    = operand_b;
    assign prod_fin = acc_add;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) product <= prod_fin;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Multi-cycle worker that sits directly downstream of the start/done handshake controller: consumes its `start` pulse and returns `ready` and `done` to it.
- Performs an unsigned (optionally signed) WIDTH x WIDTH shift-add multiply, one partial-product step per clock.
- Holds the 2*WIDTH-bit result until the next accepted operation completes.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2. The result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_l  input  1  reset, asynchronous and active-low.
- start  input  1  request to begin an operation; sampled only in IDLE.
- operand_a  input  WIDTH  multiplicand; sampled on the accepting edge.
- operand_b  input  WIDTH  multiplier; sampled on the accepting edge.
- ready  output  1  high exactly while in IDLE (can accept start).
- done  output  1  registered one-cycle completion pulse.
- product  output  2*WIDTH  result register; valid from the done cycle onward.

Behaviour:
- Reset (rst_l low, asynchronous):
  - State goes to IDLE; step counter, accumulator and operand registers clear to 0.
  - Outputs: ready=1, done=0, product=0.
- Mid-operation reset aborts immediately. No done pulse is produced and product reads 0.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - ready=1, done=0.
  - On an edge with start=1:
    - capture a into a (2*WIDTH)-bit multiplicand register, zero-extended;
    - capture b into the multiplier shift register;
    - clear accumulator and step counter;
    - go to RUN.
  - With start=0, stay in IDLE.
- RUN:
  - ready=0.
  - Each edge:
    - if the multiplier LSB is 1, the accumulator += multiplicand register;
    - then shift the multiplicand left by 1 and the multiplier right by 1;
    - increment the counter.
  - After exactly WIDTH RUN edges, go to DONE, loading product from the final accumulator value on that same edge.
- DONE:
  - done=1 and ready=0 for exactly one cycle.
  - Next edge: go to IDLE unconditionally.
- Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH -> ready high again after edge k+WIDTH+1.
  - Throughput: one operation per WIDTH+2 cycles.
- Arithmetic:
  - Accumulator is 2*WIDTH bits.
  - Unsigned overflow cannot occur: (2^WIDTH - 1)^2 < 2^(2*WIDTH).
  - The counter is ceil(log2(WIDTH+1)) bits and does not wrap within an operation.
- start while in RUN or DONE is ignored: no queueing, operands not resampled.
  - start held high continuously starts a new operation on the first IDLE edge.
- product changes only on the RUN->DONE edge (or on reset).
  - Accepting a new start does not clear product.
  - Operand changes after acceptance have no effect.
- Zero operand: all RUN steps still execute; latency is unchanged (no early termination).

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - operand_a and operand_b are two's complement.
  - On acceptance, store the absolute values and latch sign = a[MSB] XOR b[MSB].
  - On the RUN->DONE edge, product = sign ? -acc : acc (2*WIDTH-bit two's complement).
  - Latency is identical to the unsigned mode.
  - Most-negative operands are handled by treating the magnitude as unsigned WIDTH bits: -128 * -128 = +16384 for WIDTH=8.
- Undefined: purely unsigned operation as described above; no sign logic is synthesised.

Test Plan:
- WIDTH=8, a=13, b=11, single-cycle start pulse at edge k -> ready low from k+1, done=1 only in the cycle after edge k+8, product=0x008F, ready=1 after edge k+9.
- a=255, b=255 -> product=0xFE01; a=0, b=200 -> product=0x0000 with the same 10-cycle timing.
- start held high for 30 cycles with new operands each cycle -> operations accepted only on IDLE edges (every 10 cycles), each product matching the operands present on its accepting edge.
- Operation completes with product=0x008F; rst_l pulsed low mid-RUN of a second operation -> outputs go asynchronously to ready=1, done=0, product=0; no done pulse follows.
- a=0xFD, b=5:
  - with MULT_SIGNED_EN -> product=0xFFF1 (-15);
  - without the macro -> product=0x04F1 (1265);
  - with MULT_SIGNED_EN, a=0x80, b=0x80 -> 0x4000.
